// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: PC hookup, instruction-memory handshake and decode-side queue head.
// master = fetch_buffer, slave = surrounding PC/memory/decode logic.
interface fetch_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_advance;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    input  pc_addr, imem_ack, imem_rdata, flush, dec_ready,
    output pc_advance, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, count
  );

  modport slave (
    output pc_addr, imem_ack, imem_rdata, flush, dec_ready,
    input  pc_advance, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: one outstanding imem request at the PC, results queued
// as {pc, instr} in a small FIFO for decode; flush drops the queue and any in-flight fetch.
module fetch_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic           CLK,
  input logic           reset,
  fetch_buffer_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nx;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, count_nx;
  logic             push, pop, advance;

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, queue occupancy and PC load enable
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    push     = (state == REQ) && bus.imem_ack && !bus.flush;
    pop      = (count_q != '0) && bus.dec_ready && !bus.flush;
    count_nx = count_q;
    if (bus.flush) count_nx = '0;
    else           count_nx = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state)
      IDLE: begin
        if (!bus.flush && (count_q < CNT_W'(DEPTH))) state_nx = REQ;
      end
      REQ: begin
        if (bus.flush) begin
          state_nx = bus.imem_ack ? IDLE : DRAIN;
        end else if (bus.imem_ack) begin
          advance  = 1'b1;
          state_nx = (count_nx < CNT_W'(DEPTH)) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage and pointers; flush rewinds both pointers to empty
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= '{pc: bus.pc_addr, instr: bus.imem_rdata};
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_nx;
    end
  end

  // PC cannot move until pc_advance, so the fetch address is simply the PC
  assign bus.pc_advance = advance;
  assign bus.imem_req   = (state == REQ);
  assign bus.imem_addr  = bus.pc_addr;
  assign bus.dec_valid  = (count_q != '0);
  assign bus.dec_instr  = mem[rd_ptr].instr;
  assign bus.dec_pc     = mem[rd_ptr].pc;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: PC/memory environment, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_buffer;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush_r, ready_r, auto_ack, man_ack, redir_en;
  logic [31:0] man_rdata, redir_pc, pc;

  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;
  int adv0;

  ent_t        q[$];
  logic        busy, dead;
  logic [31:0] pop_log[$];

  fetch_buffer_if bus ();

  fetch_buffer dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h2008_0005 + (a << 8);
  endfunction

  // Memory: zero-wait (ack with req) in auto mode, otherwise driven by the scenarios
  assign bus.imem_ack   = auto_ack ? bus.imem_req : man_ack;
  assign bus.imem_rdata = auto_ack ? imem_word(bus.imem_addr) : man_rdata;
  assign bus.pc_addr    = pc;
  assign bus.flush      = flush_r;
  assign bus.dec_ready  = ready_r;

  // PC register: +4 on pc_advance, redirect alongside flush
  always @(posedge CLK or posedge reset) begin
    if (reset)         pc <= 32'h0;
    else if (redir_en) pc <= redir_pc;
    else if (bus.pc_advance) pc <= pc + 32'd4;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: queue of fetched entries plus "request live" / "request to discard"
  always @(negedge CLK) begin
    logic        exp_req, exp_adv, pop_m;
    int unsigned sz0;
    if (reset) begin
      q.delete();
      busy = 1'b0;
      dead = 1'b0;
      chk("rst_req",   bus.imem_req,   0);
      chk("rst_adv",   bus.pc_advance, 0);
      chk("rst_valid", bus.dec_valid,  0);
      chk("rst_count", bus.count,      0);
      chk("rst_instr", bus.dec_instr,  0);
      chk("rst_pc",    bus.dec_pc,     0);
    end else begin
      sz0     = q.size();
      exp_req = busy && !dead;
      exp_adv = exp_req && bus.imem_ack && !bus.flush;
      chk("req",   bus.imem_req,   exp_req);
      chk("adv",   bus.pc_advance, exp_adv);
      chk("valid", bus.dec_valid,  sz0 != 0);
      chk("count", bus.count,      sz0);
      if (sz0 != 0) begin
        chk("head_instr", bus.dec_instr, q[0].instr);
        chk("head_pc",    bus.dec_pc,    q[0].pc);
      end
      if (exp_req) chk("addr", bus.imem_addr, pc);
      if (bus.pc_advance) adv_cnt++;
      if (bus.dec_valid && bus.dec_ready && !bus.flush) pop_log.push_back(bus.dec_pc);

      pop_m = (sz0 != 0) && ready_r && !flush_r;
      if (flush_r) q.delete();
      else begin
        if (pop_m) void'(q.pop_front());
        if (exp_adv) q.push_back('{pc: pc, instr: bus.imem_rdata});
      end
      if (busy) begin
        if (bus.imem_ack) begin
          busy = !(dead || flush_r) && (q.size() < DEPTH);
          dead = 1'b0;
        end else if (flush_r) dead = 1'b1;
      end else if (!flush_r && sz0 < DEPTH) busy = 1'b1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    man_ack = 1'b0;
    reset   = 1'b1;
    repeat (2) step();
    reset   = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.imem_req) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_req: got timeout expected imem_req within %0d cycles", max_cyc);
  endtask

  task automatic fetch_manual(input int lat, input logic [31:0] data);
    wait_req(10);
    repeat (lat) step();
    man_ack   = 1'b1;
    man_rdata = data;
    step();
    man_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush_r = 1'b0; ready_r = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    man_rdata = '0; redir_en = 1'b0; redir_pc = '0;
    repeat (2) step();
    reset = 1'b0;

    // 1: single fetch, ack one cycle after req
    adv0 = adv_cnt;
    fetch_manual(1, 32'h2008_0005);
    @(negedge CLK); #1;
    chk("t1_valid", bus.dec_valid, 1);
    chk("t1_instr", bus.dec_instr, 32'h2008_0005);
    chk("t1_pc",    bus.dec_pc,    32'h0);
    chk("t1_count", bus.count,     1);
    chk("t1_pulses", adv_cnt - adv0, 1);
    step();

    // 5: push and pop in the same cycle at count=2
    fetch_manual(0, 32'hA000_0004);
    wait_req(10);
    pop_log.delete();
    man_ack = 1'b1; man_rdata = 32'hA000_0008; ready_r = 1'b1;
    step();
    man_ack = 1'b0; ready_r = 1'b0;
    chk("t5_count", bus.count,  2);
    chk("t5_head",  bus.dec_pc, 32'h4);
    ready_r = 1'b1;
    repeat (2) step();
    ready_r = 1'b0;
    chk("t5_npops", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("t5_pop0", pop_log[0], 32'h0);
      chk("t5_pop1", pop_log[1], 32'h4);
      chk("t5_pop2", pop_log[2], 32'h8);
    end
    chk("t5_empty", bus.count, 0);

    // 3: flush one cycle after req with ack three cycles late
    do_reset();
    fetch_manual(0, 32'h1111_0000);
    fetch_manual(0, 32'h1111_0004);
    wait_req(10);
    chk("t3_count2", bus.count, 2);
    step();
    adv0 = adv_cnt;
    flush_r = 1'b1; redir_en = 1'b1; redir_pc = 32'h40;
    step();
    flush_r = 1'b0; redir_en = 1'b0;
    chk("t3_req_drain", bus.imem_req, 0);
    chk("t3_count0",    bus.count,    0);
    step();
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    chk("t3_no_adv", adv_cnt - adv0, 0);
    chk("t3_no_push", bus.count, 0);
    wait_req(5);
    chk("t3_new_addr", bus.imem_addr, 32'h40);
    man_ack = 1'b1; man_rdata = 32'h3333_0040;
    step();
    man_ack = 1'b0;
    chk("t3_new_pc", bus.dec_pc, 32'h40);

    // 4: flush and ack in the same cycle
    wait_req(5);
    man_ack = 1'b1; man_rdata = 32'h4444_0044;
    flush_r = 1'b1; redir_en = 1'b1; redir_pc = 32'h80;
    @(negedge CLK); #1;
    chk("t4_adv", bus.pc_advance, 0);
    step();
    man_ack = 1'b0; flush_r = 1'b0; redir_en = 1'b0;
    chk("t4_count", bus.count,     0);
    chk("t4_idle",  bus.imem_req,  0);
    chk("t4_valid", bus.dec_valid, 0);
    step();
    chk("t4_reissue", bus.imem_addr, 32'h80);

    // 2: zero-wait memory fills the queue, then drains in order and resumes at 0x10
    do_reset();
    adv0 = adv_cnt;
    auto_ack = 1'b1;
    repeat (8) step();
    chk("t2_count",  bus.count,      4);
    chk("t2_req",    bus.imem_req,   0);
    chk("t2_pushes", adv_cnt - adv0, 4);
    chk("t2_head",   bus.dec_pc,     32'h0);
    pop_log.delete();
    ready_r = 1'b1;
    repeat (6) step();
    ready_r = 1'b0;
    auto_ack = 1'b0;
    chk("t2_npops", pop_log.size() >= 5, 1);
    if (pop_log.size() >= 5) begin
      chk("t2_pop0", pop_log[0], 32'h0);
      chk("t2_pop1", pop_log[1], 32'h4);
      chk("t2_pop2", pop_log[2], 32'h8);
      chk("t2_pop3", pop_log[3], 32'hC);
      chk("t2_pop4", pop_log[4], 32'h10);
    end

    // 6: reset mid-request; stale acks during and right after reset ignored
    step();
    wait_req(5);
    reset = 1'b1;
    #1;
    chk("t6_req_now",   bus.imem_req,  0);
    chk("t6_valid_now", bus.dec_valid, 0);
    step();
    man_ack = 1'b1; man_rdata = 32'hBAD0_0000;
    step();
    man_ack = 1'b0;
    step();
    reset = 1'b0;
    adv0 = adv_cnt;
    man_ack = 1'b1; man_rdata = 32'hBAD0_0001;
    step();
    man_ack = 1'b0;
    chk("t6_count", bus.count,      0);
    chk("t6_adv",   adv_cnt - adv0, 0);
    chk("t6_fresh", bus.imem_req,   1);
    chk("t6_addr",  bus.imem_addr,  32'h0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
